// File: rtl/regfile_sb_pkg.sv
// Shared register-file constants and clear-sequencer state encoding.
// No logic of its own; imported by the register file and its clear sequencer.
package regfile_sb_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_NREGS  = 16;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// Sequential clear: walks index 0..NREGS-1, one register per cycle, then idles.
// Busy for exactly NREGS cycles after a request; requests while busy are ignored.
module regfile_clr_seq
  import regfile_sb_pkg::*;
#(
  parameter int  NREGS = DEF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          Reset,
  input  logic          i_clr_req,
  output logic          o_busy,
  output logic [AW-1:0] o_idx
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clr_state_e    r_state;
  clr_state_e    w_state_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= CLR_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    o_busy      = 1'b0;
    case (r_state)
      CLR_IDLE: begin
        if (i_clr_req) begin
          w_state_nxt = CLR_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      CLR_CLEAR: begin
        o_busy = 1'b1;
        // Stop on the last index rather than wrapping.
        if (r_idx == LAST) begin
          w_state_nxt = CLR_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + AW'(1);
        end
      end
      default: w_state_nxt = CLR_IDLE;
    endcase
  end

  assign o_idx = r_idx;

endmodule

// File: rtl/regfile_sb.sv
// Two-write, two-read register file with load-pending scoreboard and sequential clear.
// Reads are combinational (optional same-cycle write bypass); writes land next edge.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int  DATA_W  = DEF_DATA_W,
  parameter int  NREGS   = DEF_NREGS,
  parameter bit  ZERO_R0 = 1'b0,
  parameter bit  BYPASS  = 1'b1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              we_a,
  input  logic [AW-1:0]     waddr_a,
  input  logic [DATA_W-1:0] wdata_a,
  input  logic              we_b,
  input  logic [AW-1:0]     waddr_b,
  input  logic [DATA_W-1:0] wdata_b,
  input  logic              mark_en,
  input  logic [AW-1:0]     mark_addr,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              busy1,
  output logic              busy2,
  input  logic              clr_req,
  output logic              clr_busy
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  r_pend;
  logic              w_clr_busy;
  logic [AW-1:0]     w_clr_idx;
  logic              w_we_a;
  logic              w_we_b;
  logic              w_mark;

  regfile_clr_seq #(.NREGS(NREGS)) u_clr_seq (
    .clk       (clk),
    .Reset     (Reset),
    .i_clr_req (clr_req),
    .o_busy    (w_clr_busy),
    .o_idx     (w_clr_idx)
  );

  assign clr_busy = w_clr_busy;

  // Clear owns the array while busy; a hard-wired r0 swallows writes and marks.
  assign w_we_a = we_a    && !w_clr_busy && !(ZERO_R0 && (waddr_a   == '0));
  assign w_we_b = we_b    && !w_clr_busy && !(ZERO_R0 && (waddr_b   == '0));
  assign w_mark = mark_en && !w_clr_busy && !(ZERO_R0 && (mark_addr == '0));

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_pend <= '0;
    end else if (w_clr_busy) begin
      r_regs[w_clr_idx] <= '0;
      r_pend[w_clr_idx] <= 1'b0;
    end else begin
      if (w_we_a) r_regs[waddr_a] <= wdata_a;
      if (w_we_b) r_regs[waddr_b] <= wdata_b;
      if (w_we_b) r_pend[waddr_b] <= 1'b0;
      if (w_mark) r_pend[mark_addr] <= 1'b1;
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [AW-1:0] addr);
    logic [DATA_W-1:0] v;
    v = r_regs[addr];
    if (BYPASS && w_we_a && (waddr_a == addr)) v = wdata_a;
    if (BYPASS && w_we_b && (waddr_b == addr)) v = wdata_b;
    if (ZERO_R0 && (addr == '0)) v = '0;
    return v;
  endfunction

  always_comb begin
    rdata1 = read_port(raddr1);
    rdata2 = read_port(raddr2);
    busy1  = r_pend[raddr1];
    busy2  = r_pend[raddr2];
  end

endmodule
